golden_nonce_queue: RTL and testbench

//  Downstream of the hasher control unit. Takes golden-nonce hits (one-cycle strobes with a 32-bit nonce),

---
 rtl/miner_pkg.sv | 22 ++
 rtl/gnq_fifo.sv | 88 ++++++++
 rtl/golden_nonce_queue.sv | 138 +++++++++++++
 tb/tb_golden_nonce_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared definitions for the golden-nonce result path: FSM encodings and field widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package miner_pkg;

    localparam int NONCE_W    = 32;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_RUN   = 2'd2
    } gnq_state_t;

    // The hasher reports nonces some fixed distance ahead of the one that
    // produced the hit; remove that offset modulo 2^32.
    function automatic logic [NONCE_W-1:0] adjust_nonce(input logic [NONCE_W-1:0] nonce,
                                                        input logic [NONCE_W-1:0] offset);
        return nonce - offset;
    endfunction

endpackage

// File: rtl/gnq_fifo.sv
// Synchronous FIFO with a registered head entry, flush and occupancy count.
// Latency: push into empty FIFO is visible at the head one cycle later.
// Backpressure: caller must only push when count<DEPTH or popping this cycle; excess pushes are ignored.
module gnq_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 36,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic          head_vld,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          pop_eff;
    logic          push_eff;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] remain;
    logic [AW-1:0] rd_nxt;

    // Qualify the handshake: pop needs a head, push needs room (a pop frees one slot).
    always_comb begin
        pop_eff   = pop & head_vld;
        push_eff  = push & ((count != FULL_CNT) | pop_eff);
        remain    = count - CW'(pop_eff);
        count_nxt = remain + CW'(push_eff);
        rd_nxt    = rd_ptr + AW'(pop_eff);
    end

    // Storage array; a flush discards the write so the slot contents do not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_eff && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; both pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_eff);
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
        end
    end

    // Registered head: bypass the incoming word when it becomes the only entry,
    // otherwise prefetch the slot the read pointer will point at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld <= 1'b0;
            head_dat <= '0;
        end else if (flush) begin
            head_vld <= 1'b0;
        end else begin
            head_vld <= (count_nxt != '0);
            if (push_eff && remain == '0) begin
                head_dat <= push_dat;
            end else if (remain != '0) begin
                head_dat <= mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/golden_nonce_queue.sv
// Golden-nonce result queue: blanks stale hits after new work, removes nonce offset, tags with work ID.
// Latency: hit accepted in cycle N appears at the head (out_valid) in cycle N+1 when the queue is empty.
// Backpressure: out_valid/out_ready handshake; hits arriving while full are dropped and counted (saturating).
// Optional feature: define GOLDEN_NONCE_DEDUP_EN to suppress repeats of the last pushed nonce within a work ID.
module golden_nonce_queue
    import miner_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int WORK_ID_W    = 4,
    parameter int BLANK_CYCLES = 253,
    parameter int NONCE_ADJUST = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 new_work,
    input  logic                 hit_valid,
    input  logic [31:0]          hit_nonce,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_nonce,
    output logic [WORK_ID_W-1:0] out_work_id,
    output logic [7:0]           drop_count,
    output logic [1:0]           state_o
);

    localparam int W  = NONCE_W + WORK_ID_W;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [BW-1:0]      BLANK_LOAD = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;
    localparam logic [CW-1:0]      FULL_CNT   = CW'(DEPTH);
    localparam logic [NONCE_W-1:0] ADJ        = NONCE_W'(NONCE_ADJUST);

    gnq_state_t           state;
    logic [BW-1:0]        blank_cnt;
    logic [WORK_ID_W-1:0] work_id;

    logic [NONCE_W-1:0]   adj_nonce;
    logic                 pop;
    logic                 eligible;
    logic                 dup;
    logic                 want;
    logic                 has_room;
    logic                 push_acc;
    logic                 full_drop;

    logic                 head_vld;
    logic [W-1:0]         head_dat;
    logic [CW-1:0]        fifo_count;

    // Work tracking: new work restarts blanking from any state; blank counter runs down to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            blank_cnt <= '0;
            work_id   <= '0;
        end else if (new_work) begin
            work_id   <= work_id + 1'b1;
            blank_cnt <= BLANK_LOAD;
            state     <= (BLANK_CYCLES == 0) ? ST_RUN : ST_BLANK;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (blank_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GOLDEN_NONCE_DEDUP_EN
    logic               last_vld;
    logic [NONCE_W-1:0] last_nonce;

    // Remember the last nonce actually stored; forgotten whenever the work changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld   <= 1'b0;
            last_nonce <= '0;
        end else if (new_work) begin
            last_vld   <= 1'b0;
        end else if (push_acc) begin
            last_vld   <= 1'b1;
            last_nonce <= adj_nonce;
        end
    end

    assign dup = last_vld & (last_nonce == adj_nonce);
`else
    assign dup = 1'b0;
`endif

    // Push qualification: only live work, never in the new_work cycle, room may come from a same-cycle pop.
    always_comb begin
        adj_nonce = adjust_nonce(hit_nonce, ADJ);
        pop       = head_vld & out_ready;
        eligible  = hit_valid & (state == ST_RUN) & ~new_work;
        want      = eligible & ~dup;
        has_room  = (fifo_count != FULL_CNT) | pop;
        push_acc  = want & has_room;
        full_drop = want & ~has_room;
    end

    // Overflow statistics survive new work; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (full_drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    gnq_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (new_work),
        .push     (push_acc),
        .push_dat ({adj_nonce, work_id}),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign out_valid   = head_vld;
    assign out_nonce   = head_dat[W-1:WORK_ID_W];
    assign out_work_id = head_dat[WORK_ID_W-1:0];
    assign state_o     = state;

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Randomized and directed bench for golden_nonce_queue against a queue-based model.
// Latency: model advances once per clock; outputs checked on the falling edge.
// Backpressure: out_ready driven directly by the stimulus.
module tb_golden_nonce_queue;

    localparam int DEPTH  = 8;
    localparam int WID_W  = 4;
    localparam int BLANK  = 4;
    localparam int ADJ    = 253;
`ifdef GOLDEN_NONCE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             new_work = 1'b0;
    logic             hit_valid = 1'b0;
    logic [31:0]      hit_nonce = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [31:0]      out_nonce;
    logic [WID_W-1:0] out_work_id;
    logic [7:0]       drop_count;
    logic [1:0]       state_o;

    int vectors = 0;
    int miscompares = 0;

    golden_nonce_queue #(
        .DEPTH        (DEPTH),
        .WORK_ID_W    (WID_W),
        .BLANK_CYCLES (BLANK),
        .NONCE_ADJUST (ADJ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .new_work    (new_work),
        .hit_valid   (hit_valid),
        .hit_nonce   (hit_nonce),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_nonce   (out_nonce),
        .out_work_id (out_work_id),
        .drop_count  (drop_count),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of tagged results plus a few scalars.
    typedef struct packed {
        logic [31:0] n;
        logic [31:0] w;
    } ent_t;

    ent_t        mq[$];
    bit          m_started;
    int          m_blank_left;
    int          m_wid;
    int          m_drop;
    bit          m_last_vld;
    logic [31:0] m_last;

    task automatic model_reset();
        mq.delete();
        m_started    = 1'b0;
        m_blank_left = 0;
        m_wid        = 0;
        m_drop       = 0;
        m_last_vld   = 1'b0;
        m_last       = '0;
    endtask

    task automatic model_step(input bit nw, input bit hv, input logic [31:0] hn, input bit rdy);
        bit          pop;
        bit          live;
        logic [31:0] adj;
        ent_t        e;
        pop = (mq.size() > 0) && rdy;
        if (nw) begin
            mq.delete();
            m_wid        = (m_wid + 1) % (1 << WID_W);
            m_started    = 1'b1;
            m_blank_left = BLANK;
            m_last_vld   = 1'b0;
        end else begin
            live = m_started && (m_blank_left == 0);
            if (m_started && m_blank_left > 0) m_blank_left--;
            if (pop) void'(mq.pop_front());
            if (hv && live) begin
                adj = hn - 32'(ADJ);
                if (!(DEDUP && m_last_vld && m_last == adj)) begin
                    if (mq.size() < DEPTH) begin
                        e.n = adj;
                        e.w = 32'(m_wid);
                        mq.push_back(e);
                        m_last_vld = 1'b1;
                        m_last     = adj;
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int exp_state;
        exp_state = !m_started ? 0 : (m_blank_left > 0 ? 1 : 2);
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("state", 32'(state_o), 32'(exp_state));
        if (mq.size() > 0) begin
            chk("out_nonce", out_nonce, mq[0].n);
            chk("out_work_id", 32'(out_work_id), mq[0].w);
        end
    endtask

    task automatic step(input bit nw, input bit hv, input logic [31:0] hn, input bit rdy);
        new_work  = nw;
        hit_valid = hv;
        hit_nonce = hn;
        out_ready = rdy;
        model_step(nw, hv, hn, rdy);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_nonce"}, out_nonce, 32'd0);
        chk({tag, "_wid"}, 32'(out_work_id), 32'd0);
        chk({tag, "_drop"}, 32'(drop_count), 32'd0);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_list[$];
        logic [31:0] prev_n;
        bit          nw;
        bit          hv;
        logic [31:0] hn;

        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        compare();

        // Hits before any work are ignored.
        step(1'b0, 1'b1, 32'h10, 1'b0);
        chk("idle_hit_valid", 32'(out_valid), 32'd0);
        chk("idle_hit_drop", 32'(drop_count), 32'd0);

        // New work, hits during blanking dropped, first live hit lands next cycle.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, $urandom, 1'b0);
        chk("blank_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 32'hA41F0000, 1'b0);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_nonce", out_nonce, 32'hA41EFF03);
        chk("first_wid", 32'(out_work_id), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Overflow: ten hits into eight slots.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h1000 + 32'(i), 1'b0);
        chk("full_drop", 32'(drop_count), 32'd2);
        chk("full_head", out_nonce, 32'h1000 - 32'd253);
        chk("model_full_size", 32'(mq.size()), 32'd8);
        step(1'b0, 1'b1, 32'h2000, 1'b1);
        chk("full_pop_push_drop", 32'(drop_count), 32'd2);
        chk("model_full_size2", 32'(mq.size()), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drained_valid", 32'(out_valid), 32'd0);

        // Flush on new work; coinciding hit never appears.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h3000 + 32'(i), 1'b0);
        step(1'b1, 1'b1, 32'hDEAD, 1'b0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h5, 1'b0);
        chk("wrap_nonce", out_nonce, 32'hFFFFFF08);
        chk("wrap_wid", 32'(out_work_id), 32'd2);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Saturating drop counter.
        for (int i = 0; i < 308; i++) step(1'b0, 1'b1, 32'h4000 + 32'(i), 1'b0);
        chk("drop_sat", 32'(drop_count), 32'hFF);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("drop_kept_on_new_work", 32'(drop_count), 32'hFF);

        // Back-to-back identical hits.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h152, 1'b0);
        step(1'b0, 1'b1, 32'h152, 1'b0);
        step(1'b0, 1'b1, 32'h153, 1'b0);
        exp_list.push_back(32'h55);
`ifndef GOLDEN_NONCE_DEDUP_EN
        exp_list.push_back(32'h55);
`endif
        exp_list.push_back(32'h56);
        foreach (exp_list[i]) begin
            chk("dedup_seq", out_nonce, exp_list[i]);
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("dedup_end_valid", 32'(out_valid), 32'd0);

        // Randomized traffic with one asynchronous reset in the middle.
        prev_n = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_n = 1'b0;
                #1;
                check_reset_values("midreset");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                compare();
            end
            nw = ($urandom_range(99) < 3);
            hv = ($urandom_range(99) < 45);
            hn = ($urandom_range(3) == 0) ? prev_n : $urandom;
            prev_n = hn;
            step(nw, hv, hn, 1'(($urandom_range(99) < 45)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
